c7bcsr_tmrctl: RTL

Timer control and interrupt-status stage for the c7bcsr CSR unit. Holds the TCFG register and decodes CSR writes to TCFG/TICLR. Drives the enable, periodic, initial-value and one-cycle init strobe into `c7bcsr_timer`. Consumes the timer's `timeval`/`intr` to provide TVAL readback and the sticky TI pending bit that feeds ESTAT.IS[11].

---
 rtl/c7bcsr_defs.sv | 16 +
 rtl/c7bcsr_tmrctl.sv | 78 +++++++
 2 files changed

// File: rtl/c7bcsr_defs.sv
// rtl/c7bcsr_defs.sv - shared CSR addresses and timer field positions for c7bcsr
package c7bcsr_defs;

    localparam int TIMER_BIT_DEF = 30;

    localparam logic [13:0] ADDR_TCFG  = 14'h41;
    localparam logic [13:0] ADDR_TVAL  = 14'h42;
    localparam logic [13:0] ADDR_TICLR = 14'h44;

    localparam int TCFG_EN_BIT       = 0;
    localparam int TCFG_PERIODIC_BIT = 1;
    localparam int TCFG_INITVAL_LSB  = 2;

    localparam int TICLR_CLR_BIT = 0;

endpackage

// File: rtl/c7bcsr_tmrctl.sv
// rtl/c7bcsr_tmrctl.sv - TCFG/TICLR decode, timer control strobes and sticky TI pending
module c7bcsr_tmrctl
    import c7bcsr_defs::*;
#(
    parameter int TIMER_BIT = TIMER_BIT_DEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   csr_wen,
    input  logic [13:0]            csr_waddr,
    input  logic [31:0]            csr_wdata,
    input  logic [13:0]            csr_raddr,
    output logic [31:0]            csr_rdata,
    input  logic [TIMER_BIT+1:0]   timeval,
    input  logic                   intr,
    output logic                   tmr_en,
    output logic                   tmr_periodic,
    output logic [TIMER_BIT-1:0]   tmr_initval,
    output logic                   tmr_init,
    output logic                   ti_pending
);

    localparam int TW = TIMER_BIT + 2;

    logic [TW-1:0] r_tcfg;
    logic          r_init;
    logic          r_pending;

    logic          w_tcfg_we;
    logic          w_ticlr_clr;
    logic          w_oneshot_stop;
    logic          w_unused_wdata;

    assign w_tcfg_we      = csr_wen && (csr_waddr == ADDR_TCFG);
    assign w_ticlr_clr    = csr_wen && (csr_waddr == ADDR_TICLR) && csr_wdata[TICLR_CLR_BIT];
    assign w_oneshot_stop = intr && !r_tcfg[TCFG_PERIODIC_BIT];
    // Upper write-data bits beyond the TCFG width are intentionally dropped.
    assign w_unused_wdata = ^csr_wdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tcfg    <= '0;
            r_init    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            // A software write takes priority over the one-shot auto-disable.
            if (w_tcfg_we) begin
                r_tcfg <= csr_wdata[TW-1:0];
            end else if (w_oneshot_stop) begin
                r_tcfg[TCFG_EN_BIT] <= 1'b0;
            end
            r_init <= w_tcfg_we;
            // Expiry wins over a coincident clear so no interrupt is lost.
            if (intr) begin
                r_pending <= 1'b1;
            end else if (w_ticlr_clr) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign tmr_en       = r_tcfg[TCFG_EN_BIT];
    assign tmr_periodic = r_tcfg[TCFG_PERIODIC_BIT];
    assign tmr_initval  = r_tcfg[TW-1:TCFG_INITVAL_LSB];
    assign tmr_init     = r_init;
    assign ti_pending   = r_pending;

    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            ADDR_TCFG:  csr_rdata[TW-1:0] = r_tcfg;
            ADDR_TVAL:  csr_rdata[TW-1:0] = timeval;
            ADDR_TICLR: csr_rdata = '0;
            default:    csr_rdata = '0;
        endcase
    end

endmodule
